// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array run controller.
//   SA_N, SA_DW      : default array dimension and operand lane width
//   sa_state_e       : run-controller state encoding
//   SA_RUN_CYCLES    : clock-enable cycles per run (3N-1)
//   SA_DRAIN_CYCLES  : cycles after the last operand word until the last PE
//                      has consumed it (2N-1)
// -----------------------------------------------------------------------------
package sa_pkg;

  localparam int SA_N  = 8;
  localparam int SA_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } sa_state_e;

  function automatic int sa_drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int sa_run_cycles(input int n);
    return 3 * n - 1;
  endfunction

  localparam int SA_RUN_CYCLES   = sa_run_cycles(SA_N);
  localparam int SA_DRAIN_CYCLES = sa_drain_cycles(SA_N);

endpackage

// File: rtl/sa_skew_buffer.sv
// -----------------------------------------------------------------------------
// sa_skew_buffer
// Triangular shift register that skews one operand word across N lanes:
// lane i of the output is the lane-i input delayed by i enabled cycles.
// Lane 0 is a gated pass-through so the first row/column of the array sees
// the word in the cycle it returns from the operand buffer; this keeps the
// final MAC of the far-corner PE inside the last enabled cycle of a run.
// Input lanes are forced to 0 when in_valid is low, so only real operand
// words ever enter the array.
//
// Ports
//   m_clk    : clock, rising edge
//   rst_n    : asynchronous active-low reset (clears all shift stages)
//   en       : shift enable (array clock-enable)
//   clr      : synchronous clear of all shift stages
//   in_valid : words carries a valid operand word this cycle
//   words    : N lanes of DW bits, unskewed
//   lanes    : N lanes of DW bits, lane i delayed by i cycles
// -----------------------------------------------------------------------------
module sa_skew_buffer #(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input  logic          m_clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [N*DW-1:0] words,
  output logic [N*DW-1:0] lanes
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] lane_in;

    assign lane_in = in_valid ? words[i*DW +: DW] : '0;

    if (i == 0) begin : g_pass
      assign lanes[DW-1:0] = lane_in;
    end else begin : g_dly
      logic [DW-1:0] sr [i];

      always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) sr[s] <= '0;
        end else if (clr) begin
          for (int s = 0; s < i; s++) sr[s] <= '0;
        end else if (en) begin
          sr[0] <= lane_in;
          for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
        end
      end

      assign lanes[i*DW +: DW] = sr[i-1];
    end
  end

endmodule

// File: rtl/sa_sequencer.sv
// -----------------------------------------------------------------------------
// sa_sequencer
// Run controller for the NxN output-stationary systolic multiplier.
// A start request clears the array for one cycle, streams N operand words
// from the operand buffer through row/column skew buffers, keeps the array
// enabled for 2N-1 further cycles so the last PE consumes the last word, and
// then pulses done. abort returns to IDLE from any busy state.
//
// Build option: define SA_SEQ_PERF_EN to enable the saturating busy-cycle
// counter on perf_cycles; otherwise perf_cycles is tied to 0.
//
// Ports
//   m_clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start, abort  : run request (IDLE only) / run cancel (busy only)
//   busy, done    : not-IDLE flag / one-cycle end-of-run pulse
//   rd_en, rd_addr: operand-buffer read strobe and word index
//   a_rd_data     : column k of A (lane i = A[i][k]), valid 1 cycle after rd_en
//   b_rd_data     : row k of B (lane j = B[k][j]), valid 1 cycle after rd_en
//   sa_clr, sa_en : array accumulator clear / PE clock-enable
//   a_west        : skewed west inputs, lane i -> array row i
//   b_north       : skewed north inputs, lane j -> array column j
//   perf_cycles   : busy-cycle counter
// -----------------------------------------------------------------------------
module sa_sequencer
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW
) (
  input  logic                 m_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [$clog2(N)-1:0] rd_addr,
  input  logic [N*DW-1:0]      a_rd_data,
  input  logic [N*DW-1:0]      b_rd_data,
  output logic                 sa_clr,
  output logic                 sa_en,
  output logic [N*DW-1:0]      a_west,
  output logic [N*DW-1:0]      b_north,
  output logic [15:0]          perf_cycles
);

  localparam int AW        = $clog2(N);
  localparam int CW        = $clog2(2 * N);
  localparam int DRAIN_CYC = sa_drain_cycles(N);

  sa_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_d, done_d, rd_en_d, sa_clr_d, sa_en_d;
  logic [AW-1:0]   rd_addr_d;
  logic            rd_vld_p0;

  // Next-state and next-output decode. Outputs are derived from the next
  // state so every control output is a flop that lines up with its state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // abort overrides any busy transition; in IDLE it is ignored so a
    // simultaneous start still launches a run.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    sa_clr_d  = (state_d == CLEAR);
    rd_en_d   = (state_d == STREAM);
    sa_en_d   = (state_d == STREAM) || (state_d == DRAIN);
    rd_addr_d = (state_d == STREAM) ? cnt_d[AW-1:0] : '0;
  end

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sa_clr  <= 1'b0;
      rd_en   <= 1'b0;
      sa_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      sa_clr  <= sa_clr_d;
      rd_en   <= rd_en_d;
      sa_en   <= sa_en_d;
      rd_addr <= rd_addr_d;
    end
  end

  // Stage p0: operand-buffer return, one cycle behind the read strobe
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p0 <= 1'b0;
    end else begin
      rd_vld_p0 <= rd_en;
    end
  end

  sa_skew_buffer #(
    .N  (N),
    .DW (DW)
  ) u_skew_a (
    .m_clk    (m_clk),
    .rst_n    (rst_n),
    .en       (sa_en),
    .clr      (sa_clr),
    .in_valid (rd_vld_p0),
    .words    (a_rd_data),
    .lanes    (a_west)
  );

  sa_skew_buffer #(
    .N  (N),
    .DW (DW)
  ) u_skew_b (
    .m_clk    (m_clk),
    .rst_n    (rst_n),
    .en       (sa_en),
    .clr      (sa_clr),
    .in_valid (rd_vld_p0),
    .words    (b_rd_data),
    .lanes    (b_north)
  );

`ifdef SA_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: doc/sa_sequencer.md
# sa_sequencer

Run controller for the N×N output-stationary systolic multiplier. On a start pulse it clears the array, reads N operand words from the operand buffer, and drives row-skewed west (A) and column-skewed north (B) streams with a clock-enable. It stops the array after exactly the number of cycles the last PE needs, then pulses done. This replaces the free-running counter and gated-clock stop used in the array top level with a proper handshake and a clock-enable.

## Interface
- N, 8, array dimension and operand depth (K = N)
- DW, 8, operand width per lane
- m_clk in 1: sole clock, rising edge
- rst_n in 1: asynchronous, active-low reset
- start in 1: request a run; sampled only in IDLE
- abort in 1: cancel the current run; no effect in IDLE
- busy out 1: high in every state except IDLE
- done out 1: one-cycle pulse at the end of a completed run
- rd_en out 1: operand-buffer read strobe
- rd_addr out $clog2(N): operand word index
- a_rd_data in N*DW: column k of A; lane i = A[i][k]; valid 1 cycle after rd_en
- b_rd_data in N*DW: row k of B; lane j = B[k][j]; valid 1 cycle after rd_en
- sa_clr out 1: synchronous accumulator clear to all PEs
- sa_en out 1: PE clock-enable
- a_west out N*DW: skewed west inputs, lane i → array row i
- b_north out N*DW: skewed north inputs, lane j → array column j
- perf_cycles out 16: busy-cycle counter (see Configuration)

## Operation
- States: IDLE → CLEAR → STREAM → DRAIN → DONE → IDLE.
- IDLE, start=1: go to CLEAR.
- CLEAR: one cycle; sa_clr=1, sa_en=0.
- STREAM: N cycles, cnt = 0..N-1; rd_en=1, rd_addr=cnt; sa_en=1.
- DRAIN: 2N-1 cycles; rd_en=0; sa_en=1.
- DONE: one cycle; done=1, sa_en=0; then IDLE.
- Total sa_en-high cycles per run: SA_RUN_CYCLES = 3N-1. For N=8 this is 23.
- Skew: returned word k enters lane i of A and lane j of B. Lane i of A is delayed i cycles; lane j of B is delayed j cycles. Lane 0 has zero added delay.
- Lanes carry 0 whenever no valid word is in flight, including during DRAIN. The skew registers shift only when sa_en=1 and clear on sa_clr.
- abort in CLEAR, STREAM, DRAIN or DONE: next state IDLE. sa_en, rd_en and done are 0 from the next cycle. No done pulse. PE results are undefined.
- start while busy: ignored. start and abort together in IDLE: start wins.
- rd_addr is $clog2(N) bits wide and does not wrap within a run.

## Timing
- Reset values: busy, done, rd_en, sa_clr and sa_en are 0; rd_addr=0; a_west=0; b_north=0; perf_cycles=0; state=IDLE.
- All outputs are registered.
- Latency: start sampled at edge t → sa_clr high in cycle t+1 → rd_en high in t+2..t+N+1 → done high in cycle t+3N+1. For N=8, done is 25 cycles after start.
- Back-to-back runs: start may be asserted in the cycle done is high. It is sampled the next cycle, in IDLE.
- Reset mid-run: asynchronous return to reset values. No done pulse.
- PE results are stable from the done cycle until the next sa_clr.

## Configuration
- SA_SEQ_PERF_EN defined: perf_cycles increments on every busy cycle. It saturates at 16'hFFFF and clears only on reset.
- SA_SEQ_PERF_EN undefined: perf_cycles is tied to 0 and no counter logic exists. The port is kept so the interface is the same in both builds.

## Structure
- Package sa_pkg holds:
  - default N and DW
  - state enum: IDLE, CLEAR, STREAM, DRAIN, DONE
  - localparams SA_RUN_CYCLES = 3N-1 and SA_DRAIN_CYCLES = 2N-1
- Sub-module sa_skew_buffer, instantiated twice (A and B).
  - Parameterised on N and DW.
  - Triangular shift register, inputs en, clr, in_valid.
- The FSM and cycle counter live in sa_sequencer.

## Test plan
- Identity: A = I8, B[k][j] = k*8+j, start → done exactly 25 cycles later. Array C equals B. sa_en high for exactly 23 cycles.
- Skew check, N=8, all words = lane index + 1: a_west lane 3 first goes non-zero 3 cycles after lane 0. All lanes return to 0 by the last DRAIN cycle.
- Abort in STREAM at cnt=4: next cycle busy=0, sa_en=0, rd_en=0. done never pulses. A following start completes normally in 25 cycles.
- Ignored start: start pulsed at cycles 5 and 10 of a run → exactly one done. The state sequence is unchanged.
- Async reset asserted mid-DRAIN, off-edge: all outputs go to 0 immediately. After release, IDLE. A subsequent run with all-ones 8-bit operands gives C[i][j] = 8·255·255 = 520200 (0x7F008), truncated to the array's 16-bit output as 0xF008.
- SA_SEQ_PERF_EN: two completed runs give perf_cycles = 50 (2 × 25 busy cycles: CLEAR 1 + STREAM 8 + DRAIN 15 + DONE 1). Undefined: perf_cycles stays 0.
